// File: rtl/program_counter.sv
// Registered fetch-address generator with increment, jump, relative branch,
// call/return through a small LIFO return-address stack, and stall.
module program_counter #(
    parameter int unsigned          WIDTH        = 8,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
    parameter int unsigned          STACK_DEPTH  = 4,
    localparam int unsigned         DW           = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             call,
    input  logic [WIDTH-1:0] call_addr,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [DW-1:0]    depth,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned   AW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_JUMP,
        OP_BRANCH,
        OP_INC
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic             push_en;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc   = pc_q + WIDTH'(1);
    // Indices wrap modulo 2^AW, so the top-of-stack slot is always push_idx-1,
    // even when a full power-of-two depth wraps push_idx to zero.
    assign push_idx = depth_q[AW-1:0];
    assign pop_idx  = push_idx - AW'(1);

    // Fixed priority: only the highest asserted request acts this cycle.
    always_comb begin
        op = OP_INC;
        if (stall)       op = OP_HOLD;
        else if (ret)    op = OP_RET;
        else if (call)   op = OP_CALL;
        else if (jump)   op = OP_JUMP;
        else if (branch) op = OP_BRANCH;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        pc_d        = pc_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push_en     = 1'b0;
        unique case (op)
            OP_HOLD: ;
            OP_RET: begin
                if (depth_q != '0) begin
                    pc_d    = stack_q[pop_idx];
                    depth_d = depth_q - DW'(1);
                end else begin
                    underflow_d = 1'b1;
                    pc_d        = pc_inc;
                end
            end
            OP_CALL: begin
                if (depth_q != DEPTH_FULL) begin
                    push_en = 1'b1;
                    depth_d = depth_q + DW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                pc_d = call_addr;
            end
            OP_JUMP:   pc_d = jump_addr;
            OP_BRANCH: pc_d = pc_q + branch_offset;
            OP_INC:    pc_d = pc_inc;
            default:   pc_d = pc_inc;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            // NOTE: the stack is small and must come up cleared, so it is
            // built from reset flops rather than an unreset RAM.
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (push_en) begin
                stack_q[push_idx] <= pc_inc;
            end
        end
    end

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: sequencing, jump, branch, call/return
// stack with overflow/underflow, stall and reset priority.
module tb_program_counter;

    localparam int unsigned   WIDTH       = 8;
    localparam logic [7:0]    RV          = 8'h10;
    localparam int unsigned   STACK_DEPTH = 4;
    localparam int unsigned   DW          = $clog2(STACK_DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             stall;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             branch;
    logic [WIDTH-1:0] branch_offset;
    logic             call;
    logic [WIDTH-1:0] call_addr;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [DW-1:0]    depth;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    program_counter #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RV),
        .STACK_DEPTH  (STACK_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_addr     (jump_addr),
        .branch        (branch),
        .branch_offset (branch_offset),
        .call          (call),
        .call_addr     (call_addr),
        .ret           (ret),
        .pc            (pc),
        .depth         (depth),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [7:0] e_pc, input logic [2:0] e_depth,
                              input logic e_ovf, input logic e_udf);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".depth"}, 32'(depth), 32'(e_depth));
        check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
        check({tag, ".udf"}, 32'(underflow), 32'(e_udf));
    endtask

    task automatic clear_ctrl();
        reset = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    // Advance one edge and settle away from it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [7:0] a);
        clear_ctrl(); jump = 1'b1; jump_addr = a; step(); clear_ctrl();
    endtask

    task automatic do_call(input logic [7:0] a);
        clear_ctrl(); call = 1'b1; call_addr = a; step(); clear_ctrl();
    endtask

    task automatic do_ret();
        clear_ctrl(); ret = 1'b1; step(); clear_ctrl();
    endtask

    initial begin
        logic [7:0] nest_ret [4];
        clear_ctrl();
        jump_addr = '0; branch_offset = '0; call_addr = '0;
        reset = 1'b1;
        step();
        expect_all("reset", 8'h10, 3'd0, 1'b0, 1'b0);
        clear_ctrl();

        // Idle sequencing from the reset vector.
        step(); check("inc1", 32'(pc), 32'h11);
        step(); check("inc2", 32'(pc), 32'h12);
        step(); check("inc3", 32'(pc), 32'h13);

        // Jump to the top of the space, then wrap.
        do_jump(8'hFF); check("jump_ff", 32'(pc), 32'hFF);
        step();         check("wrap", 32'(pc), 32'h00);

        // Relative branches, backwards and with wrap-around.
        do_jump(8'h20);
        branch = 1'b1; branch_offset = 8'hFC; step(); clear_ctrl();
        check("br_back", 32'(pc), 32'h1C);
        do_jump(8'hFD);
        branch = 1'b1; branch_offset = 8'h05; step(); clear_ctrl();
        check("br_wrap", 32'(pc), 32'h02);
        branch = 1'b1; jump = 1'b1; jump_addr = 8'h80; step(); clear_ctrl();
        check("jump_over_br", 32'(pc), 32'h80);

        // Single call / return.
        do_jump(8'h05);
        do_call(8'h40); expect_all("call1", 8'h40, 3'd1, 1'b0, 1'b0);
        step(); step(); check("sub_idle", 32'(pc), 32'h42);
        do_ret();       expect_all("ret1", 8'h06, 3'd0, 1'b0, 1'b0);

        // Nested calls from 0x06, 0xA0..0xA3; fifth overflows.
        nest_ret[0] = 8'h07; nest_ret[1] = 8'hA1; nest_ret[2] = 8'hA2; nest_ret[3] = 8'hA3;
        for (int i = 0; i < 4; i++) begin
            do_call(8'hA0 + 8'(i));
            check($sformatf("nest%0d.depth", i), 32'(depth), 32'(i + 1));
        end
        do_call(8'hA4); expect_all("call_ovf", 8'hA4, 3'd4, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            do_ret();
            check($sformatf("pop%0d.pc", i), 32'(pc), 32'(nest_ret[i]));
            check($sformatf("pop%0d.depth", i), 32'(depth), 32'(i));
        end
        do_ret();  expect_all("ret_udf", 8'h08, 3'd0, 1'b1, 1'b0 | 1'b1);
        step();    expect_all("sticky", 8'h09, 3'd0, 1'b1, 1'b1);

        // Stall dominates a simultaneous jump.
        clear_ctrl(); stall = 1'b1; jump = 1'b1; jump_addr = 8'h33;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_all($sformatf("stall%0d", i), 8'h09, 3'd0, 1'b1, 1'b1);
        end
        clear_ctrl();
        step(); check("unstall", 32'(pc), 32'h0A);

        // Simultaneous call and ret: ret wins.
        do_call(8'h50);
        do_call(8'h60); check("pre_cr.depth", 32'(depth), 32'd2);
        call = 1'b1; ret = 1'b1; call_addr = 8'h70; step(); clear_ctrl();
        check("cr.pc", 32'(pc), 32'h51);
        check("cr.depth", 32'(depth), 32'd1);

        // Reset beats stall and call with a partly filled stack.
        do_call(8'h61);
        do_call(8'h62); check("pre_rst.depth", 32'(depth), 32'd3);
        reset = 1'b1; stall = 1'b1; call = 1'b1; call_addr = 8'h99; step(); clear_ctrl();
        expect_all("rst_mid", 8'h10, 3'd0, 1'b0, 1'b0);
        do_ret(); expect_all("post_rst_ret", 8'h11, 3'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

Registered program counter for the gate-level CPU, built on the synchronous set/reset flip-flop stage. It produces the fetch address each cycle and supports sequential increment, absolute jump, PC-relative branch, subroutine call and return, and pipeline stall. Calls and returns use a small internal LIFO return-address stack, with sticky overflow and underflow error flags. The `pc` output feeds instruction memory directly.

## Interface
- `WIDTH`, 8, address width in bits; all PC arithmetic is modulo 2^WIDTH.
- `RESET_VECTOR`, 0, value loaded into `pc` on reset.
- `STACK_DEPTH`, 4, number of return-address entries; must be ≥1.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; has priority over every other input.
- `stall` input 1: freeze all state this cycle.
- `jump` input 1: load `jump_addr`.
- `jump_addr` input WIDTH: absolute target.
- `branch` input 1: add `branch_offset` to `pc`.
- `branch_offset` input WIDTH: two's-complement signed offset.
- `call` input 1: push return address and load `call_addr`.
- `call_addr` input WIDTH: subroutine target.
- `ret` input 1: pop return address into `pc`.
- `pc` output WIDTH: current fetch address (registered).
- `depth` output $clog2(STACK_DEPTH+1): number of valid stack entries.
- `overflow` output 1: sticky; a call occurred with the stack full.
- `underflow` output 1: sticky; a return occurred with the stack empty.

## Operation
- Reset: `pc`=RESET_VECTOR, `depth`=0, `overflow`=0, `underflow`=0, all stack entries cleared to 0.
- Fixed priority per cycle: reset > stall > ret > call > jump > branch > increment. Only the highest-priority asserted action takes effect; lower-priority requests that cycle are dropped, not queued.
- stall: `pc`, stack, `depth` and flags all hold.
- ret, `depth`>0: `pc` ← top entry; `depth` decrements.
- ret, `depth`=0: `underflow` ← 1; `pc` ← `pc`+1; stack unchanged.
- call, `depth`<STACK_DEPTH: push `pc`+1 (wrapped); `depth` increments; `pc` ← `call_addr`.
- call, `depth`=STACK_DEPTH: `overflow` ← 1; push discarded and existing entries preserved; `pc` ← `call_addr`.
- jump: `pc` ← `jump_addr`.
- branch: `pc` ← `pc` + `branch_offset` (full-width add, carry discarded). The offset is relative to the current `pc`, not `pc`+1.
- Otherwise: `pc` ← `pc`+1; 2^WIDTH−1 wraps to 0.
- Flags clear only on reset.
- The stack is strict LIFO and is indexed by `depth`. Entries above `depth` are don't-care apart from their reset value.

## Timing
- Every output is a register output with no combinational path from inputs to outputs.
- Latency is one cycle: a control asserted in cycle N is reflected on `pc`, `depth` and the flags after edge N+1.
- Back-to-back calls and returns on consecutive cycles are fully supported, with one stack operation per cycle.
- call and ret asserted in the same cycle: ret executes and call is ignored.
- Reset asserted mid-sequence (including during stall) wins on that edge; the stack empties.
- Output values during the reset cycle are don't-care until the first edge with `reset`=1.

## Test plan
- WIDTH=8, RESET_VECTOR=0x10. Apply reset, then 3 idle cycles -> `pc` = 0x10, 0x11, 0x12, 0x13. Then jump to 0xFF and idle 1 cycle -> `pc` = 0xFF, then 0x00.
- Branch with offset 0xFC at `pc`=0x20 -> 0x1C. Branch with offset 0x05 at `pc`=0xFD -> 0x02. Branch and jump asserted together (`jump_addr`=0x80) -> 0x80.
- At `pc`=0x05, call 0x40 -> `pc`=0x40, `depth`=1. Idle 2 cycles -> 0x42. Ret -> `pc`=0x06, `depth`=0, no flags set.
- STACK_DEPTH=4, five nested calls to 0xA0–0xA4, each issued from distinct PCs -> the fifth sets `overflow`, `pc`=0xA4, `depth` stays 4. Four rets return the first four return addresses in LIFO order. A fifth ret sets `underflow` and `pc` increments. Both flags stay 1 until reset.
- `stall`=1 with `jump`=1 (`jump_addr`=0x33) for 3 cycles -> `pc`, `depth` and flags unchanged. Release the stall -> `pc` increments. call and ret together with `depth`=2 -> pop occurs, `depth`=1, `call_addr` ignored.
- Reset asserted together with `stall`=1 and `call`=1 while `depth`=3 -> next edge gives `pc`=0x10, `depth`=0, both flags 0.
